// File: rtl/adder_share_arbiter_pkg.sv
// Shared types for the adder-sharing arbiter: FSM encoding, datapath widths
// and the latched request record.
package adder_share_arbiter_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned WIDE_WIDTH = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC_LO = 2'd1,
    EXEC_HI = 2'd2,
    RESP    = 2'd3
  } state_t;

  typedef struct packed {
    logic [WIDE_WIDTH-1:0] a;
    logic [WIDE_WIDTH-1:0] b;
    logic                  cin;
    logic                  wide;
  } req_rec_t;

endpackage

// File: rtl/adder_share_arbiter_if.sv
// Requester-side bus of the adder-sharing arbiter.
interface adder_share_arbiter_if
  import adder_share_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 2
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            wide;
  logic [NUM_REQ*WIDE_WIDTH-1:0] op_a;
  logic [NUM_REQ*WIDE_WIDTH-1:0] op_b;
  logic [NUM_REQ-1:0]            op_cin;
  logic [NUM_REQ-1:0]            gnt;
  logic                          busy;
  logic                          done;
  logic [ID_WIDTH-1:0]           owner;
  logic [WIDE_WIDTH-1:0]         sum_out;
  logic                          cout_out;

  modport master (
    output req, wide, op_a, op_b, op_cin,
    input  gnt, busy, done, owner, sum_out, cout_out
  );

  modport slave (
    input  req, wide, op_a, op_b, op_cin,
    output gnt, busy, done, owner, sum_out, cout_out
  );

endinterface

// File: rtl/adder_32_bit.sv
// 32-bit carry-select adder: ripple low half, upper half precomputed for both
// carry values and selected by the low-half carry.
module adder_32_bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [16:0] lo;
  logic [16:0] hi0;
  logic [16:0] hi1;

  assign lo  = {1'b0, a[15:0]} + {1'b0, b[15:0]} + {16'd0, cin};
  assign hi0 = {1'b0, a[31:16]} + {1'b0, b[31:16]};
  assign hi1 = {1'b0, a[31:16]} + {1'b0, b[31:16]} + 17'd1;

  assign sum  = {(lo[16] ? hi1[15:0] : hi0[15:0]), lo[15:0]};
  assign cout = lo[16] ? hi1[16] : hi0[16];

endmodule

// File: rtl/adder_share_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first asserted request at or above ptr,
// wrapping modulo N.
module rr_priority_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] idx_c,
  output logic          any_c
);

  int unsigned j;

  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr) + k) % N;
      if (!any_c && req[j]) begin
        any_c    = 1'b1;
        gnt_c[j] = 1'b1;
        idx_c    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit adder; wide ops take two passes
// with the carry held in a register between them.
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input logic                  clk,
  input logic                  rst,
  adder_share_arbiter_if.slave bus
);

  state_t                 state_q;
  state_t                 state_d;
  req_rec_t               req_q;
  logic [DATA_WIDTH-1:0]  sum_lo_q;
  logic [DATA_WIDTH-1:0]  sum_hi_q;
  logic                   carry_q;
  logic [ID_WIDTH-1:0]    rr_ptr_q;
  logic [ID_WIDTH-1:0]    next_ptr_c;

  logic [NUM_REQ-1:0]     pick_gnt_c;
  logic [ID_WIDTH-1:0]    pick_idx_c;
  logic                   pick_any_c;

  logic [DATA_WIDTH-1:0]  add_a_c;
  logic [DATA_WIDTH-1:0]  add_b_c;
  logic                   add_cin_c;
  logic [DATA_WIDTH-1:0]  add_sum_c;
  logic                   add_cout_c;

  rr_priority_picker #(.N(NUM_REQ), .IW(ID_WIDTH)) u_picker (
    .req   (bus.req),
    .ptr   (rr_ptr_q),
    .gnt_c (pick_gnt_c),
    .idx_c (pick_idx_c),
    .any_c (pick_any_c)
  );

  // Adder operands come only from the latched request, never from live op_*.
  always_comb begin
    add_a_c   = req_q.a[DATA_WIDTH-1:0];
    add_b_c   = req_q.b[DATA_WIDTH-1:0];
    add_cin_c = req_q.cin;
    if (state_q == EXEC_HI) begin
      add_a_c   = req_q.a[WIDE_WIDTH-1:DATA_WIDTH];
      add_b_c   = req_q.b[WIDE_WIDTH-1:DATA_WIDTH];
      add_cin_c = carry_q;
    end
  end

  adder_32_bit u_adder (
    .a    (add_a_c),
    .b    (add_b_c),
    .cin  (add_cin_c),
    .sum  (add_sum_c),
    .cout (add_cout_c)
  );

  assign next_ptr_c = (bus.owner == ID_WIDTH'(NUM_REQ - 1)) ? '0
                                                            : bus.owner + ID_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any_c) state_d = EXEC_LO;
      EXEC_LO: state_d = req_q.wide ? EXEC_HI : RESP;
      EXEC_HI: state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_q        <= '0;
      sum_lo_q     <= '0;
      sum_hi_q     <= '0;
      carry_q      <= 1'b0;
      rr_ptr_q     <= '0;
      bus.gnt      <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.owner    <= '0;
      bus.sum_out  <= '0;
      bus.cout_out <= 1'b0;
    end else begin
      state_q  <= state_d;
      bus.gnt  <= '0;
      bus.done <= 1'b0;
      bus.busy <= (state_d != IDLE);
      case (state_q)
        IDLE: if (pick_any_c) begin
          bus.gnt    <= pick_gnt_c;
          bus.owner  <= pick_idx_c;
          req_q.a    <= bus.op_a[pick_idx_c*WIDE_WIDTH +: WIDE_WIDTH];
          req_q.b    <= bus.op_b[pick_idx_c*WIDE_WIDTH +: WIDE_WIDTH];
          req_q.cin  <= bus.op_cin[pick_idx_c];
          req_q.wide <= bus.wide[pick_idx_c];
        end
        EXEC_LO: begin
          sum_lo_q <= add_sum_c;
          carry_q  <= add_cout_c;
        end
        EXEC_HI: begin
          sum_hi_q <= add_sum_c;
          carry_q  <= add_cout_c;
        end
        RESP: begin
          bus.done     <= 1'b1;
          bus.sum_out  <= req_q.wide ? {sum_hi_q, sum_lo_q} : {DATA_WIDTH'(0), sum_lo_q};
          bus.cout_out <= carry_q;
          rr_ptr_q     <= next_ptr_c;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one 32-bit carry-select adder (adder_32_bit, instantiated inside) between NUM_REQ requesters using round-robin arbitration.
- Each granted request is either a narrow 32-bit add or a wide 64-bit add; a wide add is sequenced over two adder passes, with the carry passed between them through a register.
- Sits beside the single-cycle CPU datapath as a multi-cycle arithmetic service for slow or extended-precision clients (address generators, 64-bit counters, debug unit).

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 32, adder width; wide operands are 2*DATA_WIDTH
ID_WIDTH, 2, width of the owner index; must equal clog2(NUM_REQ)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
req  in  NUM_REQ  per-requester request level
wide  in  NUM_REQ  per-requester op size: 1 = 64-bit, 0 = 32-bit
op_a  in  NUM_REQ*2*DATA_WIDTH  flattened operand A; requester i owns slice i
op_b  in  NUM_REQ*2*DATA_WIDTH  flattened operand B; requester i owns slice i
op_cin  in  NUM_REQ  per-requester carry-in
gnt  out  NUM_REQ  one-hot grant, one-cycle pulse
busy  out  1  high whenever the FSM is not in IDLE
done  out  1  one-cycle result-valid pulse
owner  out  ID_WIDTH  index of the requester the current/last result belongs to
sum_out  out  2*DATA_WIDTH  registered result
cout_out  out  1  registered final carry-out

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Reset values: gnt=0, busy=0, done=0, owner=0, sum_out=0, cout_out=0. Internal state: FSM=IDLE, rr pointer=0.
- FSM states: IDLE, EXEC_LO, EXEC_HI, RESP.
- IDLE:
  - If req is nonzero, select the first asserted req searching upward from the rr pointer, wrapping modulo NUM_REQ.
  - In that cycle: pulse gnt[winner]; latch the operand slice, wide bit and cin into internal registers; latch winner into owner.
  - Next state: EXEC_LO.
  - If req is zero, stay in IDLE.
- EXEC_LO:
  - Adder inputs: latched A[31:0], latched B[31:0], latched cin.
  - Register the sum into sum_lo and the adder cout into carry_reg.
  - Next state: EXEC_HI if latched wide=1, else RESP.
- EXEC_HI:
  - Adder inputs: latched A[63:32], latched B[63:32], carry_reg.
  - Register the sum into sum_hi and the adder cout into carry_reg.
  - Next state: RESP.
- RESP:
  - done=1 for exactly this cycle.
  - Narrow op: sum_out = {32'b0, sum_lo}.
  - Wide op: sum_out = {sum_hi, sum_lo}.
  - cout_out = carry_reg.
  - rr pointer = (owner+1) mod NUM_REQ.
  - Next state: IDLE.
- Hold behaviour:
  - sum_out, cout_out and owner hold their values until the next RESP (owner until the next grant).
  - The adder inputs are driven only from latched registers; op_* may change freely after the grant.
- Latency, with grant in cycle T: narrow done at T+2; wide done at T+3. Peak throughput is one narrow op per 3 cycles.
- Request rule: a request is consumed at its grant. If req[i] is still high when the FSM next reaches IDLE, it counts as a new request. req changes while busy are ignored.
- Simultaneous requests: only one winner per IDLE cycle. The rr pointer guarantees each requester waits at most NUM_REQ-1 other grants.
- Single requester: it is re-granted every 3 or 4 cycles; the pointer wraps with no starvation.
- Overflow: plain modular arithmetic; the 64-bit wrap is reported only through cout_out. No signed-overflow flag.
- Reset mid-operation: the op is aborted, no done pulse, rr pointer returns to 0, all outputs return to their reset values on the next edge.
- Invalid state encodings recover to IDLE.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE=2'd0, EXEC_LO=2'd1, EXEC_HI=2'd2, RESP=2'd3);
  - DATA_WIDTH and WIDE_WIDTH = 2*DATA_WIDTH;
  - the request record layout (a, b, cin, wide).
- One natural sub-module: rr_priority_picker. It is combinational: inputs req and pointer, outputs one-hot grant and index. It is reused by later arbiters.
- The adder is the existing adder_32_bit, instantiated once, unmodified.

Test Plan:
- Narrow add: reset, then req=4'b0001, wide=0, A=0x00000000_FFFFFFFF, B=1, cin=0 -> gnt=0001 at T; done at T+2; sum_out=0x0; cout_out=1; owner=0.
- Wide add with carry across halves: req0 wide=1, A=0x00000000_FFFFFFFF, B=1, cin=0 -> done at T+3; sum_out=0x00000001_00000000; cout_out=0.
- Wide full wrap: A=0xFFFFFFFF_FFFFFFFF, B=0, cin=1 -> sum_out=0; cout_out=1; done at T+3.
- Round-robin: req=4'b1111 held high, narrow ops -> grant order 0,1,2,3,0 with grants 3 cycles apart; owner matches each done.
- Fairness after a partial set: pointer at 2 (last owner 1), req=4'b0011 -> grant to 0 (wraps past 2,3), then 1.
- Reset mid-op: assert rst in EXEC_HI of a wide op -> no done pulse; outputs 0 next cycle; the next req3 and req0 pair grants 0 first.
